// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, load/store and RAM-side signals of the shared SRAM port.
// slave is the arbiter's view; master is the core plus RAM macro.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int RAM_AW = 10
);
    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_gnt;
    logic              inst_rvalid;
    logic [31:0]       inst_rdata;
    logic              data_req;
    logic [3:0]        data_we;
    logic [ADDR_W-1:0] data_addr;
    logic [31:0]       data_wdata;
    logic              data_gnt;
    logic              data_rvalid;
    logic [31:0]       data_rdata;
    logic              ram_en;
    logic [3:0]        ram_we;
    logic [RAM_AW-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;
    modport slave (
        input  inst_req, inst_addr, data_req, data_we, data_addr, data_wdata, ram_rdata,
        output inst_gnt, inst_rvalid, inst_rdata, data_gnt, data_rvalid, data_rdata,
               ram_en, ram_we, ram_addr, ram_wdata
    );
    modport master (
        output inst_req, inst_addr, data_req, data_we, data_addr, data_wdata, ram_rdata,
        input  inst_gnt, inst_rvalid, inst_rdata, data_gnt, data_rvalid, data_rdata,
               ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port SRAM between fetch and load/store, data first with fetch anti-starvation.
// Optional macro ARB_RR_EN replaces the starvation counter with alternating priority on contention.
module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int RAM_AW   = 10,
    parameter int MAX_WAIT = 3
) (
    input logic clk,
    input logic rst,
    mem_port_arbiter_if.slave bus
);
    logic       inst_gnt;
    logic       data_gnt;
    logic       both;
    logic [3:0] wait_cnt;
    logic [3:0] wait_nxt;
    logic [1:0] rd_owner;
`ifdef ARB_RR_EN
    logic last_inst;
    always_comb begin
        both     = bus.inst_req & bus.data_req;
        inst_gnt = !rst && bus.inst_req && (!bus.data_req || !last_inst);
        data_gnt = !rst && bus.data_req && !inst_gnt;
        wait_nxt = '0;
    end
    always_ff @(posedge clk)
        last_inst <= rst ? 1'b1 : (both ? inst_gnt : last_inst);
`else
    always_comb begin
        both     = bus.inst_req & bus.data_req;
        inst_gnt = !rst && bus.inst_req && (!bus.data_req || wait_cnt == 4'(MAX_WAIT));
        data_gnt = !rst && bus.data_req && !inst_gnt;
        wait_nxt = (rst || inst_gnt || !bus.inst_req) ? 4'd0 :
                   (wait_cnt == 4'(MAX_WAIT) ? wait_cnt : wait_cnt + 4'd1);
    end
`endif
    always_ff @(posedge clk) begin
        wait_cnt <= wait_nxt;
        rd_owner <= rst ? 2'b00 : {inst_gnt, data_gnt && bus.data_we == 4'd0};
    end
    assign bus.inst_gnt    = inst_gnt;
    assign bus.data_gnt    = data_gnt;
    assign bus.ram_en      = inst_gnt | data_gnt;
    assign bus.ram_addr    = data_gnt ? bus.data_addr[RAM_AW+1:2] : bus.inst_addr[RAM_AW+1:2];
    assign bus.ram_we      = data_gnt ? bus.data_we : 4'd0;
    assign bus.ram_wdata   = bus.data_wdata;
    assign bus.inst_rvalid = rd_owner[1];
    assign bus.data_rvalid = rd_owner[0];
    assign bus.inst_rdata  = bus.ram_rdata;
    assign bus.data_rdata  = bus.ram_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of grants, RAM strobes and read return routing.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int errors = 0;
    logic [31:0] mem [0:1023];
    logic [7:0] pat;
    always #5 clk = ~clk;
    mem_port_arbiter_if #(.ADDR_W(32), .RAM_AW(10)) bus ();
    mem_port_arbiter #(.ADDR_W(32), .RAM_AW(10), .MAX_WAIT(3)) dut (.clk(clk), .rst(rst), .bus(bus));
    always @(posedge clk)
        if (bus.ram_en) begin
            for (int b = 0; b < 4; b++)
                if (bus.ram_we[b]) mem[bus.ram_addr][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
            if (bus.ram_we == 4'd0) bus.ram_rdata <= mem[bus.ram_addr];
        end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic step;
        @(posedge clk);
        #1;
    endtask
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[0]  = 32'h3C010001;
        mem[1]  = 32'h00010840;
        mem[2]  = 32'h10000004;
        mem[17] = 32'h11223344;
        rst = 1'b1;
        bus.inst_req = 1'b1;
        bus.inst_addr = 32'h0;
        bus.data_req = 1'b1;
        bus.data_we = 4'hF;
        bus.data_addr = 32'h44;
        bus.data_wdata = 32'hFFFFFFFF;
        bus.ram_rdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_inst_gnt", 32'(bus.inst_gnt), 0);
            chk("rst_data_gnt", 32'(bus.data_gnt), 0);
            chk("rst_ram_en", 32'(bus.ram_en), 0);
            chk("rst_ram_we", 32'(bus.ram_we), 0);
            chk("rst_inst_rvalid", 32'(bus.inst_rvalid), 0);
        end
        step;
        rst = 1'b0;
        bus.data_req = 1'b0;
        bus.data_we = 4'h0;
        @(negedge clk);
        chk("f0_gnt", 32'(bus.inst_gnt), 1);
        chk("f0_ram_en", 32'(bus.ram_en), 1);
        chk("f0_ram_addr", 32'(bus.ram_addr), 0);
        chk("f0_ram_we", 32'(bus.ram_we), 0);
        chk("f0_rvalid", 32'(bus.inst_rvalid), 0);
        step;
        bus.inst_addr = 32'h4;
        @(negedge clk);
        chk("f1_gnt", 32'(bus.inst_gnt), 1);
        chk("f1_ram_addr", 32'(bus.ram_addr), 1);
        chk("f0_ret_rvalid", 32'(bus.inst_rvalid), 1);
        chk("f0_ret_rdata", bus.inst_rdata, 32'h3C010001);
        step;
        bus.inst_addr = 32'h8;
        @(negedge clk);
        chk("f2_gnt", 32'(bus.inst_gnt), 1);
        chk("f1_ret_rvalid", 32'(bus.inst_rvalid), 1);
        chk("f1_ret_rdata", bus.inst_rdata, 32'h00010840);
        chk("f1_ret_drvalid", 32'(bus.data_rvalid), 0);
        step;
        bus.inst_req = 1'b0;
        @(negedge clk);
        chk("idle_gnt", 32'(bus.inst_gnt), 0);
        chk("idle_ram_en", 32'(bus.ram_en), 0);
        chk("f2_ret_rvalid", 32'(bus.inst_rvalid), 1);
        chk("f2_ret_rdata", bus.inst_rdata, 32'h10000004);
        step;
        bus.data_req = 1'b1;
        bus.data_we = 4'hF;
        bus.data_addr = 32'h40;
        bus.data_wdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("idle_rvalid", 32'(bus.inst_rvalid), 0);
        chk("st_gnt", 32'(bus.data_gnt), 1);
        chk("st_ram_we", 32'(bus.ram_we), 32'hF);
        chk("st_ram_addr", 32'(bus.ram_addr), 32'h10);
        chk("st_ram_wdata", bus.ram_wdata, 32'hDEADBEEF);
        step;
        bus.data_we = 4'h0;
        @(negedge clk);
        chk("ld_gnt", 32'(bus.data_gnt), 1);
        chk("ld_ram_we", 32'(bus.ram_we), 0);
        chk("st_no_rvalid", 32'(bus.data_rvalid), 0);
        step;
        bus.data_req = 1'b0;
        @(negedge clk);
        chk("ld_rvalid", 32'(bus.data_rvalid), 1);
        chk("ld_inst_rvalid", 32'(bus.inst_rvalid), 0);
        chk("ld_rdata", bus.data_rdata, 32'hDEADBEEF);
        step;
        bus.data_req = 1'b1;
        bus.data_we = 4'b0010;
        bus.data_addr = 32'h47;
        bus.data_wdata = 32'h0000AB00;
        @(negedge clk);
        chk("bst_gnt", 32'(bus.data_gnt), 1);
        chk("bst_ram_addr", 32'(bus.ram_addr), 32'h11);
        chk("bst_ram_we", 32'(bus.ram_we), 32'h2);
        step;
        bus.data_we = 4'h0;
        bus.data_addr = 32'h44;
        step;
        bus.data_req = 1'b0;
        @(negedge clk);
        chk("bld_rvalid", 32'(bus.data_rvalid), 1);
        chk("bld_rdata", bus.data_rdata, 32'h1122AB44);
        step;
        bus.inst_req = 1'b1;
        bus.inst_addr = 32'h0;
        @(negedge clk);
        chk("mid_gnt", 32'(bus.inst_gnt), 1);
        step;
        rst = 1'b1;
        bus.inst_req = 1'b0;
        @(negedge clk);
        chk("mid_rst_gnt", 32'(bus.inst_gnt), 0);
        step;
        @(negedge clk);
        chk("mid_rst_drop", 32'(bus.inst_rvalid), 0);
        step;
        rst = 1'b0;
        bus.inst_req = 1'b1;
        bus.inst_addr = 32'h8;
        bus.data_req = 1'b1;
        bus.data_we = 4'h0;
        bus.data_addr = 32'h40;
`ifdef ARB_RR_EN
        pat = 8'b1010_1010;
`else
        pat = 8'b1000_1000;
`endif
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("cont%0d_inst_gnt", i), 32'(bus.inst_gnt), 32'(pat[i]));
            chk($sformatf("cont%0d_data_gnt", i), 32'(bus.data_gnt), 32'(!pat[i]));
`ifndef ARB_RR_EN
            chk($sformatf("cont%0d_wait_cnt", i), 32'(dut.wait_cnt), 32'(i % 4));
`endif
            step;
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
